// File: rtl/bcd_counter_pkg.sv
// ============================================================================
// bcd_counter_pkg : shared widths, limits and FSM states for bcd_counter4
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_counter_pkg;

  localparam int              BCD_W      = 4;
  localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
  localparam int              NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  function automatic logic bcd_legal(input logic [BCD_W-1:0] v);
    return (v <= BCD_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// bcd_digit : one BCD decade with combinational carry/borrow out
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;
  logic             at_limit;

  assign at_limit = up ? (q_q == BCD_MAX) : (q_q == '0);
  assign cout     = en & cin & at_limit;

  // An out-of-range code is scrubbed on any tick and never propagates a carry.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      if (!bcd_legal(q_q)) begin
        q_d = '0;
      end else if (cin) begin
        if (at_limit) q_d = up ? '0 : BCD_MAX;
        else          q_d = up ? (q_q + 1'b1) : (q_q - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/bcd_counter4.sv
// ============================================================================
// bcd_counter4 : four-decade BCD up/down counter with run/pause/clear control
// Optional lap (display freeze) when BCD_COUNTER4_LAP_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_counter4
  import bcd_counter_pkg::*;
#(
  parameter int TICK_DIV = 50000
)
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_stop,
  input  logic                        clear,
  input  logic                        dir,
`ifdef BCD_COUNTER4_LAP_EN
  input  logic                        lap,
`endif
  output logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic                        running,
  output logic                        wrap
);

  localparam int                TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_e                      state_q;
  logic [TICK_W-1:0]           presc_q;
  logic                        running_q;
  logic                        wrap_q;
  logic                        tick;
  logic [NUM_DIGITS:0]         carry;
  logic [NUM_DIGITS*BCD_W-1:0] live;

  assign tick     = (state_q == RUN) && (presc_q == TICK_LAST);
  assign carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .en    (tick),
        .up    (dir),
        .cin   (carry[i]),
        .q     (live[i*BCD_W +: BCD_W]),
        .cout  (carry[i+1])
      );
    end
  endgenerate

  // Carry out of the top decade marks the full 9999<->0000 rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (clear) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= carry[NUM_DIGITS];
      case (state_q)
        IDLE: begin
          if (start_stop) begin
            state_q   <= RUN;
            presc_q   <= '0;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          presc_q <= tick ? '0 : (presc_q + 1'b1);
          if (start_stop) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (start_stop) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          presc_q   <= '0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCD_COUNTER4_LAP_EN
  logic                        frozen_q;
  logic [NUM_DIGITS*BCD_W-1:0] hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frozen_q <= 1'b0;
      hold_q   <= '0;
    end else if (clear) begin
      frozen_q <= 1'b0;
    end else if (lap) begin
      frozen_q <= !frozen_q;
      if (!frozen_q) hold_q <= live;
    end
  end

  assign digits = frozen_q ? hold_q : live;
`else
  assign digits = live;
`endif

  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter4.sv
// ============================================================================
// tb_bcd_counter4 : scoreboard bench for bcd_counter4 (directed + random)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_counter4;

  localparam int TICK_DIV = 4;
`ifdef BCD_COUNTER4_LAP_EN
  localparam bit HAS_LAP = 1'b1;
`else
  localparam bit HAS_LAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        dir = 1'b1;
  logic        lap = 1'b0;
  logic [15:0] digits;
  logic        running;
  logic        wrap;

  always #5 clk = ~clk;

  bcd_counter4 #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .dir        (dir),
`ifdef BCD_COUNTER4_LAP_EN
    .lap        (lap),
`endif
    .digits     (digits),
    .running    (running),
    .wrap       (wrap)
  );

  typedef struct {
    int          cyc;
    logic [15:0] dig;
    logic        run;
    logic        wr;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain decimal count, stopwatch-style run/paused flags.
  int   m_cnt, m_pre, m_hold;
  bit   m_run, m_paused, m_wrap, m_frozen;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_hold = 0;
    m_run = 0; m_paused = 0; m_wrap = 0; m_frozen = 0;
  endtask

  // Drive one cycle of inputs, predict the outputs after the next edge, wait it.
  task automatic step(input bit ss, input bit clr, input bit d, input bit lp);
    bit tick;
    int old;
    start_stop = ss; clear = clr; dir = d; lap = lp;
    tick = m_run && (m_pre == TICK_DIV - 1);
    old  = m_cnt;
    if (clr) begin
      m_run = 0; m_paused = 0; m_pre = 0; m_cnt = 0; m_wrap = 0; m_frozen = 0;
    end else begin
      m_wrap = 0;
      if (tick) begin
        if (d) begin m_wrap = (old == 9999); m_cnt = (old + 1) % 10000; end
        else   begin m_wrap = (old == 0);    m_cnt = (old + 9999) % 10000; end
      end
      if (HAS_LAP && lap) begin
        if (m_frozen) m_frozen = 0;
        else begin m_frozen = 1; m_hold = old; end
      end
      if (m_run) m_pre = (m_pre + 1) % TICK_DIV;
      if (ss) begin
        if (m_run)         begin m_run = 0; m_paused = 1; end
        else if (m_paused) begin m_run = 1; m_paused = 0; end
        else               begin m_run = 1; m_pre = 0; end
      end
    end
    sbq.push_back('{cyc + 1, to_bcd(m_frozen ? m_hold : m_cnt), m_run, m_wrap});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    sbq.delete();
    start_stop = 0; clear = 0; lap = 0;
    rst_n = 1'b0;
    #1;
    check("rst_digits", digits, 0);
    check("rst_running", running, 0);
    check("rst_wrap", wrap, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        if (e.cyc < cyc) begin
          check("sb_missed_cycle", e.cyc, cyc);
        end else begin
          check("sb_digits", digits, e.dig);
          check("sb_running", running, e.run);
          check("sb_wrap", wrap, e.wr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rdir;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Count up 40 clocks from start: ten steps.
    step(1, 0, 1, 0);
    repeat (40) step(0, 0, 1, 0);
    check("up40_digits", digits, 16'h0010);
    repeat (113 * TICK_DIV) step(0, 0, 1, 0);
    check("up_to_0123", digits, 16'h0123);
    do_reset();

    // Down from zero rolls to 9999, then back up through 0000.
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    check("down_9999", digits, 16'h9999);
    check("down_wrap", wrap, 1);
    step(0, 0, 0, 0);
    check("down_wrap_1cyc", wrap, 0);
    repeat (3) step(0, 0, 0, 0);
    check("down_9998", digits, 16'h9998);
    repeat (4) step(0, 0, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    check("up_0000", digits, 16'h0000);
    check("up_wrap", wrap, 1);

    // Pause with prescaler at 2, resume: step lands two cycles later.
    step(0, 1, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    check("paused_running", running, 0);
    repeat (20) step(0, 0, 1, 0);
    check("paused_hold", digits, 16'h0000);
    step(1, 0, 1, 0);
    check("resume_running", running, 1);
    step(0, 0, 1, 0);
    check("resume_not_yet", digits, 16'h0000);
    step(0, 0, 1, 0);
    check("resume_step", digits, 16'h0001);

    // clear beats start_stop.
    step(1, 1, 1, 0);
    check("clr_ss_digits", digits, 16'h0000);
    check("clr_ss_running", running, 0);

    if (HAS_LAP) begin
      step(1, 0, 1, 0);
      repeat (20) step(0, 0, 1, 0);
      step(0, 0, 1, 1);
      check("lap_freeze", digits, 16'h0005);
      repeat (31) step(0, 0, 1, 0);
      check("lap_held", digits, 16'h0005);
      step(0, 0, 1, 1);
      check("lap_release", digits, 16'h0013);
      step(0, 1, 1, 0);
    end

    // Random control traffic; dir wanders between ticks.
    rdir = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 8) == 0) rdir = ~rdir;
      if (i == 1500) do_reset();
      step(($urandom % 16) == 0, ($urandom % 97) == 0, rdir, ($urandom % 23) == 0);
    end
    start_stop = 0; clear = 0; lap = 0;
    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
